// File: rtl/blink_ctrl.sv
// Multi-channel LED blinker: shared tick prescaler and PWM counter, per-channel
// OFF/ON/BLINK/PWM modes, and a single-entry config port applied on tick edges.
module blink_ctrl #(
  parameter int unsigned CLK_HZ   = 12_000_000,
  parameter int unsigned TICK_HZ  = 1000,
  parameter int unsigned CHANNELS = 4,
  parameter int unsigned PWM_BITS = 8,
  parameter int unsigned HP_BITS  = 16
) (
  input  logic                clk12MHz,
  input  logic                rst_n,
  input  logic                cfg_valid,
  output logic                cfg_ready,
  input  logic [3:0]          cfg_chan,
  input  logic [1:0]          cfg_mode,
  input  logic [HP_BITS-1:0]  cfg_half_period,
  input  logic [PWM_BITS-1:0] cfg_duty,
  output logic [CHANNELS-1:0] led,
  output logic                tick
);

  localparam int unsigned DIV   = CLK_HZ / TICK_HZ;
  localparam int unsigned PRE_W = (DIV > 1) ? $clog2(DIV) : 1;

  typedef enum logic [1:0] {
    M_OFF   = 2'd0,
    M_ON    = 2'd1,
    M_BLINK = 2'd2,
    M_PWM   = 2'd3
  } mode_e;

  logic [PRE_W-1:0]    r_pre;
  logic [PRE_W-1:0]    w_pre_nxt;
  logic                r_tick;
  logic [PWM_BITS-1:0] r_pwm;

  logic                r_ready;
  logic                r_pend;
  logic [3:0]          r_p_chan;
  mode_e               r_p_mode;
  logic [HP_BITS-1:0]  r_p_hp;
  logic [PWM_BITS-1:0] r_p_duty;
  logic                w_apply;

  logic [CHANNELS-1:0] w_led_nxt;
  logic [CHANNELS-1:0] r_led;

  assign w_pre_nxt = (r_pre == PRE_W'(DIV - 1)) ? '0 : r_pre + PRE_W'(1);
  assign w_apply   = r_pend && r_tick;

  // Time base: prescaler wraps every DIV clocks; tick marks the last count.
  always_ff @(posedge clk12MHz or negedge rst_n) begin
    if (!rst_n) begin
      r_pre  <= '0;
      r_tick <= 1'b0;
      r_pwm  <= '0;
    end else begin
      r_pre  <= w_pre_nxt;
      r_tick <= (w_pre_nxt == PRE_W'(DIV - 1));
      r_pwm  <= r_pwm + PWM_BITS'(1);
    end
  end

  // Single pending config slot; ready is low from accept until the apply tick.
  always_ff @(posedge clk12MHz or negedge rst_n) begin
    if (!rst_n) begin
      r_ready  <= 1'b1;
      r_pend   <= 1'b0;
      r_p_chan <= '0;
      r_p_mode <= M_OFF;
      r_p_hp   <= '0;
      r_p_duty <= '0;
    end else if (cfg_valid && r_ready) begin
      r_ready  <= 1'b0;
      r_pend   <= 1'b1;
      r_p_chan <= cfg_chan;
      r_p_mode <= mode_e'(cfg_mode);
      r_p_hp   <= cfg_half_period;
      r_p_duty <= cfg_duty;
    end else if (w_apply) begin
      r_ready <= 1'b1;
      r_pend  <= 1'b0;
    end
  end

  for (genvar g = 0; g < CHANNELS; g++) begin : g_ch
    mode_e               r_mode;
    logic [HP_BITS-1:0]  r_hp;
    logic [HP_BITS-1:0]  r_cnt;
    logic [PWM_BITS-1:0] r_duty;
    logic                r_phase;
    logic                w_sel;
    logic [HP_BITS-1:0]  w_lim;

    assign w_sel = w_apply && (r_p_chan == 4'(g));
    // Half-period 0 is treated as 1, so the wrap limit saturates at 0.
    assign w_lim = (r_hp == '0) ? '0 : r_hp - HP_BITS'(1);

    // Channel state: load on apply, otherwise advance the blink counter on ticks.
    always_ff @(posedge clk12MHz or negedge rst_n) begin
      if (!rst_n) begin
        r_mode  <= M_OFF;
        r_hp    <= '0;
        r_cnt   <= '0;
        r_duty  <= '0;
        r_phase <= 1'b0;
      end else if (w_sel) begin
        r_mode  <= r_p_mode;
        r_hp    <= r_p_hp;
        r_duty  <= r_p_duty;
        r_cnt   <= '0;
        r_phase <= 1'b1;
      end else if (r_tick && (r_mode == M_BLINK)) begin
        if (r_cnt == w_lim) begin
          r_cnt   <= '0;
          r_phase <= ~r_phase;
        end else begin
          r_cnt <= r_cnt + HP_BITS'(1);
        end
      end
    end

    // LED function of the current channel state.
    always_comb begin
      w_led_nxt[g] = 1'b0;
      case (r_mode)
        M_OFF:   w_led_nxt[g] = 1'b0;
        M_ON:    w_led_nxt[g] = 1'b1;
        M_BLINK: w_led_nxt[g] = r_phase;
        M_PWM:   w_led_nxt[g] = (r_pwm < r_duty);
        default: w_led_nxt[g] = 1'b0;
      endcase
    end
  end

  // Registered LED drive.
  always_ff @(posedge clk12MHz or negedge rst_n) begin
    if (!rst_n) begin
      r_led <= '0;
    end else begin
      r_led <= w_led_nxt;
    end
  end

  assign led       = r_led;
  assign tick      = r_tick;
  assign cfg_ready = r_ready;

endmodule

// File: tb/tb_blink_ctrl.sv
// Directed bench for blink_ctrl with DIV=12, 4 channels, 4-bit PWM.
module tb_blink_ctrl;

  localparam int unsigned DIV = 12;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        cfg_valid;
  logic        cfg_ready;
  logic [3:0]  cfg_chan;
  logic [1:0]  cfg_mode;
  logic [15:0] cfg_half_period;
  logic [3:0]  cfg_duty;
  logic [3:0]  led;
  logic        tick;

  int tests = 0;
  int fails = 0;
  int t     = 0;
  int n     = 0;

  always #5 clk = ~clk;

  blink_ctrl #(
    .CLK_HZ  (12_000),
    .TICK_HZ (1000),
    .CHANNELS(4),
    .PWM_BITS(4),
    .HP_BITS (16)
  ) dut (
    .clk12MHz       (clk),
    .rst_n          (rst_n),
    .cfg_valid      (cfg_valid),
    .cfg_ready      (cfg_ready),
    .cfg_chan       (cfg_chan),
    .cfg_mode       (cfg_mode),
    .cfg_half_period(cfg_half_period),
    .cfg_duty       (cfg_duty),
    .led            (led),
    .tick           (tick)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_led(input string tag, input logic [3:0] exp);
    check(tag, 32'(led), 32'(exp));
  endtask

  task automatic chk_bit(input string tag, input logic obs, input logic exp);
    check(tag, 32'(obs), 32'(exp));
  endtask

  // Advance n falling edges; t counts cycles relative to the last sync point.
  task automatic step(input int k);
    repeat (k) begin
      @(negedge clk);
      t++;
    end
  endtask

  task automatic at_t(input int target);
    step(target - t);
  endtask

  // Count falling edges until a tick cycle is observed (bounded).
  task automatic count_to_tick(output int cnt);
    cnt = 0;
    do begin
      @(negedge clk);
      cnt++;
    end while (tick !== 1'b1 && cnt < 40);
  endtask

  // Sync to the next tick cycle; that cycle becomes t=0.
  task automatic wait_tick();
    int c;
    count_to_tick(c);
    chk_bit("tick_seen", tick, 1'b1);
    t = 0;
  endtask

  task automatic send(input logic [3:0] ch, input logic [1:0] md,
                      input logic [15:0] hp, input logic [3:0] dt);
    cfg_valid       = 1'b1;
    cfg_chan        = ch;
    cfg_mode        = md;
    cfg_half_period = hp;
    cfg_duty        = dt;
    step(1);
    cfg_valid = 1'b0;
  endtask

  // Accept at t=1->2, applied at the edge closing tick cycle t=12; returns at t=13.
  task automatic cfg_apply(input logic [3:0] ch, input logic [1:0] md,
                           input logic [15:0] hp, input logic [3:0] dt);
    wait_tick();
    step(1);
    send(ch, md, hp, dt);
    chk_bit("ready_low", cfg_ready, 1'b0);
    at_t(13);
    chk_bit("ready_back", cfg_ready, 1'b1);
  endtask

  task automatic count_high(input int b, output int cnt);
    cnt = 0;
    for (int i = 0; i < 16; i++) begin
      step(1);
      if (led[b] === 1'b1) cnt++;
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, observed timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n           = 1'b0;
    cfg_valid       = 1'b0;
    cfg_chan        = '0;
    cfg_mode        = '0;
    cfg_half_period = '0;
    cfg_duty        = '0;
    repeat (3) @(negedge clk);
    chk_led("reset_led", 4'b0000);
    chk_bit("reset_ready", cfg_ready, 1'b1);
    chk_bit("reset_tick", tick, 1'b0);

    // The tick cycle is the DIV-th cycle, counting the one in which reset releases.
    rst_n = 1'b1;
    count_to_tick(n);
    check("first_tick", 32'(n), 32'(DIV - 1));
    count_to_tick(n);
    check("tick_period", 32'(n), 32'(DIV));

    // BLINK ch1 half_period=3: rises 2 edges after the tick, toggles every 36 clocks.
    cfg_apply(4'd1, 2'd2, 16'd3, 4'd0);
    chk_led("blink_pre", 4'b0000);
    at_t(14);  chk_led("blink_rise", 4'b0010);
    at_t(49);  chk_led("blink_hold_hi", 4'b0010);
    at_t(50);  chk_led("blink_fall", 4'b0000);
    at_t(85);  chk_led("blink_hold_lo", 4'b0000);
    at_t(86);  chk_led("blink_rise2", 4'b0010);

    // Rewrite ch1 while its phase is low: restarts with phase=1, cnt=0.
    at_t(122); chk_led("restart_before", 4'b0000);
    send(4'd1, 2'd2, 16'd3, 4'd0);
    chk_bit("restart_ready_low", cfg_ready, 1'b0);
    at_t(133); chk_led("restart_pre", 4'b0000);
    at_t(134); chk_led("restart_rise", 4'b0010);
    at_t(169); chk_led("restart_hold", 4'b0010);
    at_t(170); chk_led("restart_fall", 4'b0000);

    cfg_apply(4'd1, 2'd0, 16'd0, 4'd0);
    at_t(14);  chk_led("ch1_off", 4'b0000);

    // PWM on ch2.
    cfg_apply(4'd2, 2'd3, 16'd0, 4'd5);
    at_t(14);
    count_high(2, n);
    check("pwm_duty5", 32'(n), 32'd5);
    cfg_apply(4'd2, 2'd3, 16'd0, 4'd0);
    at_t(14);
    count_high(2, n);
    check("pwm_duty0", 32'(n), 32'd0);
    cfg_apply(4'd2, 2'd3, 16'd0, 4'd15);
    at_t(14);
    count_high(2, n);
    check("pwm_duty15", 32'(n), 32'd15);
    cfg_apply(4'd2, 2'd0, 16'd0, 4'd0);
    at_t(14);  chk_led("ch2_off", 4'b0000);

    // Handshake: valid held high; second request waits for ready.
    wait_tick();
    step(1);
    cfg_valid = 1'b1;
    cfg_chan  = 4'd0;
    cfg_mode  = 2'd1;
    step(1);
    chk_bit("hs_first_accept", cfg_ready, 1'b0);
    cfg_chan = 4'd3;
    at_t(12);
    chk_bit("hs_tick", tick, 1'b1);
    chk_bit("hs_ready_held", cfg_ready, 1'b0);
    at_t(13);
    chk_bit("hs_ready_back", cfg_ready, 1'b1);
    chk_led("hs_led_pre", 4'b0000);
    at_t(14);
    cfg_valid = 1'b0;
    chk_bit("hs_second_accept", cfg_ready, 1'b0);
    chk_led("hs_ch0_on", 4'b0001);
    at_t(25);
    chk_bit("hs_ready_back2", cfg_ready, 1'b1);
    chk_led("hs_ch3_pre", 4'b0001);
    at_t(26);
    chk_led("hs_ch3_on", 4'b1001);

    // Accept in a tick cycle: applies one full DIV later.
    wait_tick();
    send(4'd0, 2'd0, 16'd0, 4'd0);
    chk_bit("tk_ready_low", cfg_ready, 1'b0);
    at_t(12);
    chk_bit("tk_ready_held", cfg_ready, 1'b0);
    chk_led("tk_led_held", 4'b1001);
    at_t(13);
    chk_bit("tk_ready_back", cfg_ready, 1'b1);
    chk_led("tk_led_pre", 4'b1001);
    at_t(14);
    chk_led("tk_applied", 4'b1000);

    // half_period=0 on ch3 toggles every tick.
    cfg_apply(4'd3, 2'd2, 16'd0, 4'd0);
    at_t(14);  chk_led("hp0_rise", 4'b1000);
    at_t(25);  chk_led("hp0_hold", 4'b1000);
    at_t(26);  chk_led("hp0_fall", 4'b0000);
    at_t(37);  chk_led("hp0_low", 4'b0000);
    at_t(38);  chk_led("hp0_rise2", 4'b1000);

    cfg_apply(4'd3, 2'd0, 16'd0, 4'd0);
    at_t(14);  chk_led("ch3_off", 4'b0000);

    // Out-of-range channel is consumed with no effect.
    cfg_apply(4'd7, 2'd1, 16'd0, 4'd0);
    at_t(14);  chk_led("chan7_none", 4'b0000);
    at_t(30);  chk_led("chan7_none_late", 4'b0000);

    // Reset with a request pending.
    cfg_apply(4'd0, 2'd1, 16'd0, 4'd0);
    at_t(14);  chk_led("pre_reset_on", 4'b0001);
    wait_tick();
    at_t(10);
    send(4'd3, 2'd1, 16'd0, 4'd0);
    chk_bit("pend_ready_low", cfg_ready, 1'b0);
    at_t(12);
    chk_bit("pend_tick", tick, 1'b1);
    rst_n = 1'b0;
    #1;
    chk_led("mid_reset_led", 4'b0000);
    chk_bit("mid_reset_ready", cfg_ready, 1'b1);
    chk_bit("mid_reset_tick", tick, 1'b0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    count_to_tick(n);
    check("mid_reset_first_tick", 32'(n), 32'(DIV - 1));
    count_to_tick(n);
    step(2);
    chk_led("pending_discarded", 4'b0000);
    chk_bit("post_reset_ready", cfg_ready, 1'b1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/blink_ctrl.md
# blink_ctrl

Parametrised multi-channel LED blinker, the next generation of the single-LED `blink` block. It drives `CHANNELS` LED outputs from the 12 MHz board clock. Each channel is configured independently at run time to OFF, ON, BLINK (programmable half-period in ticks) or PWM (programmable duty). Configuration enters through a valid/ready port and is applied atomically on the next tick boundary.

## Interface
- `CLK_HZ`, 12_000_000, input clock frequency; `CLK_HZ/TICK_HZ` must be an integer ≥ 2.
- `TICK_HZ`, 1000, blink time-base rate (1 ms tick by default).
- `CHANNELS`, 4, number of LED outputs (1..16).
- `PWM_BITS`, 8, PWM counter and duty width.
- `HP_BITS`, 16, half-period field width.
- `clk12MHz`, in, 1, system clock, rising edge.
- `rst_n`, in, 1, asynchronous active-low reset; release is synchronous to `clk12MHz`.
- `cfg_valid`, in, 1, configuration request.
- `cfg_ready`, out, 1, block can accept a configuration.
- `cfg_chan`, in, 4, target channel index.
- `cfg_mode`, in, 2, mode: 0 OFF, 1 ON, 2 BLINK, 3 PWM.
- `cfg_half_period`, in, HP_BITS, BLINK half-period in ticks; 0 is treated as 1.
- `cfg_duty`, in, PWM_BITS, PWM on-count per PWM period.
- `led`, out, CHANNELS, registered LED drive, active-high.
- `tick`, out, 1, one-cycle time-base pulse, exported for debug and test.

## Operation
- **Prescaler.** Counts 0..DIV-1 with DIV = CLK_HZ/TICK_HZ. `tick` is high during the cycle where the count equals DIV-1. The count then wraps to 0.
- **PWM counter.** Free-running, PWM_BITS wide, increments every clock and wraps naturally. Shared by all channels.
- **Per-channel state.**
  - `mode` (2 bits), `half_period`, `duty`.
  - `cnt` (HP_BITS), the tick counter.
  - `phase` (1 bit).
- **Config handshake.**
  - A request is accepted on a rising edge where `cfg_valid && cfg_ready`. All cfg fields are captured into a pending register.
  - `cfg_ready` drops to 0 in the following cycle and stays low while the request is pending.
  - `cfg_valid` while `cfg_ready` is 0 is ignored, with no queueing.
- **Apply.**
  - The pending request is applied at the edge closing the next tick cycle. If the accept itself happens in a tick cycle, the request waits for the following tick.
  - On apply, the target channel loads mode, half_period and duty, and sets `cnt` = 0 and `phase` = 1.
  - That channel does no counting on the apply tick.
  - `cfg_ready` returns to 1 the cycle after apply.
  - If `cfg_chan` ≥ CHANNELS, the request is consumed with no effect.
- **BLINK counting.** On each tick, for channels in BLINK that are not being applied this tick:
  - if `cnt` == max(half_period,1)-1, then `cnt` ← 0 and `phase` toggles;
  - otherwise `cnt` increments.
- **OFF, ON and PWM.** `cnt` and `phase` hold.
- **LED function**, registered each cycle:
  - OFF → 0
  - ON → 1
  - BLINK → `phase`
  - PWM → (`pwm_cnt` < `duty`); duty 0 gives constant 0, and the maximum duty gives (2^PWM_BITS − 1)/2^PWM_BITS.
- **Reset (any time, including with a request pending).**
  - Prescaler 0, `pwm_cnt` 0, `tick` 0.
  - All channels OFF with `cnt` 0 and `phase` 0.
  - `led` = 0 and `cfg_ready` = 1.
  - The pending request is discarded.

## Timing
- The tick period is exactly DIV clocks. The first `tick` comes DIV cycles after reset release.
- Config latency:
  - accept at edge A; the next tick cycle is T;
  - channel state updates at the edge ending T;
  - `led` shows the new mode from the cycle after that, i.e. 2 edges after T starts;
  - `cfg_ready` is high again in cycle T+1.
- BLINK: `led` is high for max(half_period,1) ticks, then low for the same, and repeats. Every edge is aligned to a tick plus 1 cycle.
- PWM period is 2^PWM_BITS clocks and has no tick dependence.
- Worst-case handshake turnaround is DIV+1 cycles.

## Test plan
Use CLK_HZ=12_000, TICK_HZ=1000 (DIV=12), CHANNELS=4, PWM_BITS=4 unless noted.
1. **Reset.** Assert `rst_n`=0 mid-run with a request pending → `led`=0000, `cfg_ready`=1, `tick`=0 immediately. After release, the first `tick` comes 12 cycles later and the pending request is never applied.
2. **BLINK.** Write ch1 BLINK with half_period=3 → `led[1]` rises 2 edges after the next tick, then toggles every 36 clocks (3 ticks). Other channels stay 0.
3. **PWM.** Write ch2 PWM with duty=5 → `led[2]` is high 5 of every 16 clocks. duty=0 → constant 0; duty=15 → high 15 of 16.
4. **Handshake.** Hold `cfg_valid` high with ch0 ON, then ch3 ON → the second request is accepted only after `cfg_ready` returns (a separate tick). A request accepted during a tick cycle applies one full DIV later.
5. **Boundaries.**
   - BLINK with half_period=0 behaves as half_period=1 (toggle every tick).
   - `cfg_chan`=7 → consumed, `led` unchanged, `cfg_ready` returns after the tick.
   - Re-writing BLINK to a channel mid-cycle restarts it with `phase`=1 and `cnt`=0.
